// File: rtl/cdc_afifo_pkg.sv
// Shared types and constants for the asynchronous FIFO read-side output stage.
package cdc_afifo_pkg;

  // Number of words the read-side skid buffer can hold.
  localparam int CDC_AFIFO_FWFT_DEPTH = 3;

  // Circular-buffer pointer, wraps 2 -> 0.
  typedef logic [1:0] cdc_afifo_fwft_ptr_t;

  // Occupancy of the skid buffer, 0..3.
  typedef logic [1:0] cdc_afifo_fwft_cnt_t;

  // Advance a buffer pointer, wrapping after the last entry.
  function automatic cdc_afifo_fwft_ptr_t fwft_ptr_next(input cdc_afifo_fwft_ptr_t p);
    if (p == cdc_afifo_fwft_ptr_t'(CDC_AFIFO_FWFT_DEPTH - 1)) begin
      return '0;
    end
    return cdc_afifo_fwft_ptr_t'(p + 2'd1);
  endfunction

endpackage

// File: rtl/cdc_afifo_rd_fwft.sv
// Read-side first-word-fall-through stage of the asynchronous FIFO.
// Issues reads to the registered-read memory / gray counter, captures the
// returned word one cycle later into a 3-entry skid buffer and presents the
// buffer head on a valid/ready stream. The read strobe never depends on
// i_ready, so there is no combinational path from the consumer back to the
// pointer logic.
// Optional feature: define CDC_AFIFO_FWFT_POPCNT_EN to build a 32-bit
// accepted-beat counter on o_pop_cnt; otherwise o_pop_cnt is tied to 0.
module cdc_afifo_rd_fwft
  import cdc_afifo_pkg::*;
#(
  parameter int dbits = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_empty,
  output logic             o_rd_ena,
  input  logic [dbits-1:0] i_rdata,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [dbits-1:0] o_data,
  output logic [31:0]      o_pop_cnt
);

  logic [dbits-1:0]    mem_q [0:CDC_AFIFO_FWFT_DEPTH-1];
  logic [dbits-1:0]    mem_d [0:CDC_AFIFO_FWFT_DEPTH-1];
  cdc_afifo_fwft_ptr_t wr_ptr_q, wr_ptr_d;
  cdc_afifo_fwft_ptr_t rd_ptr_q, rd_ptr_d;
  cdc_afifo_fwft_cnt_t count_q, count_d;
  logic                inflight_q, inflight_d;
  logic                rd_ena;
  logic                pop;
  logic [2:0]          committed;

  // Read strobe: only when words exist upstream and a slot is guaranteed
  // for every word already requested plus this one.
  always_comb begin
    committed = {1'b0, count_q} + {2'b00, inflight_q};
    rd_ena    = !i_empty && (committed < 3'(CDC_AFIFO_FWFT_DEPTH));
    pop       = (count_q != '0) && i_ready;
  end

  assign o_rd_ena = rd_ena;
  assign o_valid  = (count_q != '0);
  assign o_data   = mem_q[rd_ptr_q];

  // Next-state: capture the returning word, retire the popped head, track occupancy.
  always_comb begin
    for (int i = 0; i < CDC_AFIFO_FWFT_DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    inflight_d = rd_ena;

    if (inflight_q) begin
      mem_d[wr_ptr_q] = i_rdata;
      wr_ptr_d        = fwft_ptr_next(wr_ptr_q);
    end

    if (pop) begin
      rd_ptr_d = fwft_ptr_next(rd_ptr_q);
    end

    // Capture and pop in the same cycle cancel out.
    case ({inflight_q, pop})
      2'b10:   count_d = cdc_afifo_fwft_cnt_t'(count_q + 2'd1);
      2'b01:   count_d = cdc_afifo_fwft_cnt_t'(count_q - 2'd1);
      default: count_d = count_q;
    endcase
  end

  // State registers; reset discards buffered and in-flight words.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < CDC_AFIFO_FWFT_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= 1'b0;
    end else begin
      for (int i = 0; i < CDC_AFIFO_FWFT_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
    end
  end

`ifdef CDC_AFIFO_FWFT_POPCNT_EN
  logic [31:0] pop_cnt_q, pop_cnt_d;

  // Accepted-beat counter, wraps naturally at 2^32.
  always_comb begin
    pop_cnt_d = pop_cnt_q;
    if (pop) begin
      pop_cnt_d = pop_cnt_q + 32'd1;
    end
  end

  // Counter register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pop_cnt_q <= '0;
    end else begin
      pop_cnt_q <= pop_cnt_d;
    end
  end

  assign o_pop_cnt = pop_cnt_q;
`else
  assign o_pop_cnt = '0;
`endif

endmodule

// File: tb/tb_cdc_afifo_rd_fwft.sv
// Directed testbench for cdc_afifo_rd_fwft with a small upstream model:
// a word source, a registered empty flag derived from the read index, and a
// registered-read memory returning src[idx] one cycle after o_rd_ena.
module tb_cdc_afifo_rd_fwft;

`ifdef CDC_AFIFO_FWFT_POPCNT_EN
  localparam bit POPCNT = 1'b1;
`else
  localparam bit POPCNT = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_empty;
  logic        o_rd_ena;
  logic [7:0]  i_rdata;
  logic        o_valid;
  logic        i_ready;
  logic [7:0]  o_data;
  logic [31:0] o_pop_cnt;

  logic [7:0]  src [0:31];
  int          avail;
  int          rd_idx;
  int          issued;
  int          checks = 0;
  int          errors = 0;

  always #5 i_clk = ~i_clk;

  cdc_afifo_rd_fwft #(.dbits(8)) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_empty   (i_empty),
    .o_rd_ena  (o_rd_ena),
    .i_rdata   (i_rdata),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_data    (o_data),
    .o_pop_cnt (o_pop_cnt)
  );

  assign i_empty = (rd_idx >= avail);

  // Upstream model: gray counter advance plus registered-read memory.
  always @(posedge i_clk) begin
    if (i_rst) begin
      rd_idx <= 0;
      issued <= 0;
    end else if (o_rd_ena) begin
      i_rdata <= src[rd_idx];
      rd_idx  <= rd_idx + 1;
      issued  <= issued + 1;
    end
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_pop(input int n);
    return POPCNT ? 32'(n) : 32'd0;
  endfunction

  task automatic do_reset();
    avail = 0;
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
  endtask

  initial begin
    int got;
    i_rst   = 1'b1;
    i_ready = 1'b1;
    avail   = 0;
    rd_idx  = 0;
    issued  = 0;
    i_rdata = '0;
    for (int i = 0; i < 32; i++) src[i] = 8'(i);
    step();
    step();

    // Reset state with an empty FIFO for 10 cycles.
    i_rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      chk("idle_rd_ena", {31'd0, o_rd_ena}, 32'd0);
      chk("idle_valid",  {31'd0, o_valid},  32'd0);
      chk("idle_data",   {24'd0, o_data},   32'd0);
      chk("idle_popcnt", o_pop_cnt,         32'd0);
    end

    // Single word 0xA5.
    do_reset();
    step();
    src[0] = 8'hA5;
    avail  = 1;
    #1;
    chk("single_rd_ena_t", {31'd0, o_rd_ena}, 32'd1);
    chk("single_valid_t",  {31'd0, o_valid},  32'd0);
    step();
    chk("single_rd_ena_t1", {31'd0, o_rd_ena}, 32'd0);
    chk("single_valid_t1",  {31'd0, o_valid},  32'd0);
    step();
    chk("single_valid_t2", {31'd0, o_valid}, 32'd1);
    chk("single_data_t2",  {24'd0, o_data},  32'hA5);
    step();
    chk("single_valid_t3", {31'd0, o_valid}, 32'd0);
    chk("single_popcnt",   o_pop_cnt,        exp_pop(1));
    chk("single_issued",   32'(issued),      32'd1);

    // Streaming 16 words with i_ready held high.
    do_reset();
    step();
    for (int i = 0; i < 32; i++) src[i] = 8'(i);
    avail = 16;
    #1;
    chk("stream_valid_t", {31'd0, o_valid}, 32'd0);
    step();
    chk("stream_valid_t1", {31'd0, o_valid}, 32'd0);
    step();
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("stream_valid_%0d", k), {31'd0, o_valid}, 32'd1);
      chk($sformatf("stream_data_%0d", k),  {24'd0, o_data},  32'(k));
      step();
    end
    chk("stream_valid_end", {31'd0, o_valid}, 32'd0);
    chk("stream_issued",    32'(issued),      32'd16);
    chk("stream_popcnt",    o_pop_cnt,        exp_pop(16));

    // Backpressure: 8 words, consumer stalled for 6 cycles.
    do_reset();
    step();
    i_ready = 1'b0;
    avail   = 8;
    #1;
    chk("bp_rd_ena_t", {31'd0, o_rd_ena}, 32'd1);
    step();
    chk("bp_rd_ena_t1", {31'd0, o_rd_ena}, 32'd1);
    step();
    chk("bp_rd_ena_t2", {31'd0, o_rd_ena}, 32'd1);
    chk("bp_data_t2",   {24'd0, o_data},   32'd0);
    step();
    chk("bp_rd_ena_t3", {31'd0, o_rd_ena}, 32'd0);
    chk("bp_data_t3",   {24'd0, o_data},   32'd0);
    step();
    chk("bp_rd_ena_t4", {31'd0, o_rd_ena}, 32'd0);
    chk("bp_data_t4",   {24'd0, o_data},   32'd0);
    step();
    chk("bp_issued_stall", 32'(issued),      32'd3);
    chk("bp_valid_stall",  {31'd0, o_valid}, 32'd1);
    chk("bp_data_stall",   {24'd0, o_data},  32'd0);
    chk("bp_popcnt_stall", o_pop_cnt,        32'd0);
    step();
    i_ready = 1'b1;
    #1;
    got = 0;
    for (int c = 0; c < 40 && got < 8; c++) begin
      if (o_valid) begin
        chk($sformatf("bp_data_%0d", got), {24'd0, o_data}, 32'(got));
        got++;
      end
      step();
    end
    chk("bp_count",  32'(got),  32'd8);
    step();
    chk("bp_valid_end", {31'd0, o_valid}, 32'd0);
    chk("bp_issued",    32'(issued),      32'd8);
    chk("bp_popcnt",    o_pop_cnt,        exp_pop(8));

    // Empty rises the cycle after a read issue; in-flight word still lands.
    do_reset();
    step();
    src[0] = 8'h3C;
    src[1] = 8'hC3;
    avail  = 2;
    #1;
    chk("emp_rd_ena_t", {31'd0, o_rd_ena}, 32'd1);
    step();
    chk("emp_rd_ena_t1", {31'd0, o_rd_ena}, 32'd1);
    step();
    chk("emp_rd_ena_t2", {31'd0, o_rd_ena}, 32'd0);
    chk("emp_valid_t2",  {31'd0, o_valid},  32'd1);
    chk("emp_data_t2",   {24'd0, o_data},   32'h3C);
    step();
    chk("emp_rd_ena_t3", {31'd0, o_rd_ena}, 32'd0);
    chk("emp_valid_t3",  {31'd0, o_valid},  32'd1);
    chk("emp_data_t3",   {24'd0, o_data},   32'hC3);
    step();
    chk("emp_valid_t4", {31'd0, o_valid}, 32'd0);
    chk("emp_issued",   32'(issued),      32'd2);

    // Reset with count=2 and a read in flight.
    do_reset();
    step();
    for (int i = 0; i < 32; i++) src[i] = 8'(i);
    i_ready = 1'b1;
    avail   = 8;
    step();
    step();
    chk("rst_pre_data", {24'd0, o_data}, 32'd0);
    step();
    i_ready = 1'b0;
    #1;
    chk("rst_pre_rd_ena_t3", {31'd0, o_rd_ena}, 32'd1);
    step();
    chk("rst_pre_rd_ena_t4", {31'd0, o_rd_ena}, 32'd0);
    chk("rst_pre_data_t4",   {24'd0, o_data},   32'd1);
    chk("rst_pre_popcnt",    o_pop_cnt,         exp_pop(1));
    avail = 0;
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    chk("rst_valid",  {31'd0, o_valid}, 32'd0);
    chk("rst_popcnt", o_pop_cnt,        32'd0);
    chk("rst_data",   {24'd0, o_data},  32'd0);
    step();
    chk("rst_valid_after",  {31'd0, o_valid},  32'd0);
    chk("rst_rd_ena_after", {31'd0, o_rd_ena}, 32'd0);
    step();
    chk("rst_valid_after2", {31'd0, o_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
